// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder for the host init sequence (CMD0/8/55/ACMD41/58).
// Optional CRC7 command checking is enabled by defining SD_RESP_CRC_CHECK_EN.
module sd_spi_card_responder #(
  parameter int unsigned NCR_BITS   = 8,
  parameter int unsigned BUSY_POLLS = 2,
  parameter int unsigned CCS        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       card_ready,
  output logic       cmd_strobe,
  output logic [5:0] last_cmd
);

  localparam logic [6:0] NCR_LAST = 7'(NCR_BITS);
  localparam logic [6:0] POLL_MAX = 7'(BUSY_POLLS);
  localparam logic       CCS_BIT  = 1'(CCS);

  typedef enum logic [1:0] {HUNT, CMD, NCR, RESP} state_t;

  logic [1:0] sclk_q, cs_q, mosi_q;
  logic       sclk_d;
  logic       sclk_s, cs_s, mosi_s, rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '1;
      sclk_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[0], sclk};
      cs_q   <= {cs_q[0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      sclk_d <= sclk_q[1];
    end
  end

  assign sclk_s = sclk_q[1];
  assign cs_s   = cs_q[1];
  assign mosi_s = mosi_q[1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

  state_t      state, state_n;
  // sr holds frame[45:1] by the 48th rise; the start/tx bits are implied by the hunt.
  logic [44:0] sr, sr_n;
  logic        saw_zero, saw_zero_n;
  logic [5:0]  bit_cnt, bit_cnt_n;
  logic [6:0]  ncr_cnt, ncr_cnt_n;
  logic [39:0] resp_sr, resp_sr_n;
  logic [5:0]  bits_left, bits_left_n;
  logic        miso_n, strobe_n;
  logic [5:0]  last_n;
  logic        idle_flag, idle_n, app_cmd, app_n, ready_n;
  logic [6:0]  poll_cnt, poll_n;

  logic [5:0]  idx;
  logic [31:0] arg;
  logic        crc_ok;
  logic [7:0]  dec_r1;
  logic [31:0] dec_data;
  logic        dec_long, dec_idle, dec_ready, dec_app;
  logic [6:0]  dec_polls;

  assign idx = sr[44:39];
  assign arg = sr[38:7];

`ifdef SD_RESP_CRC_CHECK_EN
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = d[39 - i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign crc_ok = (crc7({2'b01, sr[44:7]}) == sr[6:0]);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    dec_r1    = {7'b0, idle_flag};
    dec_data  = '0;
    dec_long  = 1'b0;
    dec_idle  = idle_flag;
    dec_ready = card_ready;
    dec_app   = 1'b0;
    dec_polls = poll_cnt;
    if (!crc_ok) begin
      dec_r1  = 8'h08 | {7'b0, idle_flag};
      dec_app = app_cmd;
    end else begin
      case (idx)
        6'd0: begin
          dec_r1    = 8'h01;
          dec_idle  = 1'b1;
          dec_ready = 1'b0;
          dec_polls = '0;
        end
        6'd8: begin
          dec_long = 1'b1;
          dec_data = {20'h0, (arg[11:8] == 4'h1) ? 4'h1 : 4'h0, arg[7:0]};
        end
        6'd55: dec_app = 1'b1;
        6'd41: begin
          if (!app_cmd) begin
            dec_r1 = 8'h04 | {7'b0, idle_flag};
          end else if (poll_cnt < POLL_MAX) begin
            dec_r1    = 8'h01;
            dec_polls = poll_cnt + 7'd1;
          end else begin
            dec_r1    = 8'h00;
            dec_idle  = 1'b0;
            dec_ready = 1'b1;
          end
        end
        6'd58: begin
          dec_long = 1'b1;
          dec_data = {card_ready, card_ready & CCS_BIT, 6'h0, 24'hFF8000};
        end
        default: dec_r1 = 8'h04 | {7'b0, idle_flag};
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    saw_zero_n  = saw_zero;
    bit_cnt_n   = bit_cnt;
    ncr_cnt_n   = ncr_cnt;
    resp_sr_n   = resp_sr;
    bits_left_n = bits_left;
    miso_n      = miso;
    strobe_n    = 1'b0;
    last_n      = last_cmd;
    idle_n      = idle_flag;
    app_n       = app_cmd;
    ready_n     = card_ready;
    poll_n      = poll_cnt;
    if (cs_s) begin
      state_n    = HUNT;
      miso_n     = 1'b1;
      sr_n       = '0;
      saw_zero_n = 1'b0;
      bit_cnt_n  = '0;
    end else begin
      case (state)
        HUNT: if (rise) begin
          if (!mosi_s) begin
            saw_zero_n = 1'b1;
          end else if (saw_zero) begin
            saw_zero_n = 1'b0;
            sr_n       = '0;
            bit_cnt_n  = 6'd2;
            state_n    = CMD;
          end
        end
        CMD: if (rise) begin
          sr_n      = {sr[43:0], mosi_s};
          bit_cnt_n = bit_cnt + 6'd1;
          if (bit_cnt == 6'd47) begin
            strobe_n    = 1'b1;
            last_n      = idx;
            idle_n      = dec_idle;
            ready_n     = dec_ready;
            app_n       = dec_app;
            poll_n      = dec_polls;
            resp_sr_n   = {dec_r1, dec_data};
            bits_left_n = dec_long ? 6'd39 : 6'd7;
            ncr_cnt_n   = '0;
            state_n     = NCR;
          end
        end
        NCR: if (fall) begin
          if (ncr_cnt == NCR_LAST) begin
            miso_n    = resp_sr[39];
            resp_sr_n = {resp_sr[38:0], 1'b0};
            state_n   = RESP;
          end else begin
            miso_n    = 1'b1;
            ncr_cnt_n = ncr_cnt + 7'd1;
          end
        end
        RESP: if (fall) begin
          if (bits_left == '0) begin
            miso_n     = 1'b1;
            saw_zero_n = 1'b0;
            state_n    = HUNT;
          end else begin
            miso_n      = resp_sr[39];
            resp_sr_n   = {resp_sr[38:0], 1'b0};
            bits_left_n = bits_left - 6'd1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      sr         <= '0;
      saw_zero   <= 1'b0;
      bit_cnt    <= '0;
      ncr_cnt    <= '0;
      resp_sr    <= '0;
      bits_left  <= '0;
      miso       <= 1'b1;
      cmd_strobe <= 1'b0;
      last_cmd   <= '0;
      idle_flag  <= 1'b1;
      app_cmd    <= 1'b0;
      card_ready <= 1'b0;
      poll_cnt   <= '0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      saw_zero   <= saw_zero_n;
      bit_cnt    <= bit_cnt_n;
      ncr_cnt    <= ncr_cnt_n;
      resp_sr    <= resp_sr_n;
      bits_left  <= bits_left_n;
      miso       <= miso_n;
      cmd_strobe <= strobe_n;
      last_cmd   <= last_n;
      idle_flag  <= idle_n;
      app_cmd    <= app_n;
      card_ready <= ready_n;
      poll_cnt   <= poll_n;
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: directed command table, abort/reset sequences,
// and random command streams checked against a card-state reference model.
module tb_sd_spi_card_responder;

  localparam int unsigned NCR  = 8;
  localparam int unsigned BUSY = 2;
  localparam int unsigned CCSV = 1;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b1;
  logic       miso, card_ready, cmd_strobe;
  logic [5:0] last_cmd;

  sd_spi_card_responder #(.NCR_BITS(NCR), .BUSY_POLLS(BUSY), .CCS(CCSV)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .card_ready(card_ready), .cmd_strobe(cmd_strobe), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  int strobes = 0;
  always @(posedge clk) if (cmd_strobe) strobes <= strobes + 1;

  int asserts = 0;
  int fails = 0;

  // Reference card state
  int m_idle = 1, m_ready = 0, m_app = 0, m_polls = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // CRC7 as the remainder of d*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic model_step(input logic [5:0] idx, input logic [31:0] arg, input bit bad,
                            output logic [7:0] r1, output logic [31:0] data, output bit long);
    int was_app;
    was_app = m_app;
    r1 = 8'(m_idle);
    data = '0;
    long = 0;
    if (bad) begin
      r1 = 8'h08 | 8'(m_idle);
      return;
    end
    m_app = (idx == 6'd55) ? 1 : 0;
    if (idx == 6'd0) begin
      r1 = 8'h01; m_idle = 1; m_ready = 0; m_polls = 0;
    end else if (idx == 6'd8) begin
      long = 1;
      data = 32'(arg[7:0]) + ((arg[11:8] == 4'h1) ? 32'h100 : 32'h0);
    end else if (idx == 6'd55) begin
      r1 = 8'(m_idle);
    end else if (idx == 6'd41 && was_app == 1) begin
      if (m_polls < int'(BUSY)) begin
        r1 = 8'h01; m_polls++;
      end else begin
        r1 = 8'h00; m_idle = 0; m_ready = 1;
      end
    end else if (idx == 6'd58) begin
      long = 1;
      data = 32'hFF8000 + (m_ready != 0 ? 32'h8000_0000 : 0)
           + ((m_ready != 0 && CCSV != 0) ? 32'h4000_0000 : 0);
    end else begin
      r1 = 8'h04 | 8'(m_idle);
    end
  endtask

  task automatic xfer(input logic b, output logic r);
    mosi = b;
    #HALF;
    sclk = 1'b1;
    r = miso;
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [47:0] frame, input int n);
    logic d;
    for (int i = 47; i > 47 - n; i--) xfer(frame[i], d);
  endtask

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg, input bit bad);
    logic [6:0] c;
    c = ref_crc7({2'b01, idx, arg}) ^ (bad ? 7'h01 : 7'h00);
    return {2'b01, idx, arg, c, 1'b1};
  endfunction

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg, input bit bad,
                         input logic [7:0] exp_r1, input logic [31:0] exp_data, input bit exp_long,
                         input bit exp_ready);
    logic [63:0] exp_s, got_s;
    logic [39:0] resp;
    logic        b;
    int          nresp, s0;
    s0 = strobes;
    cs_n = 1'b0;
    send_bits(mk_frame(idx, arg, bad), 48);
    nresp = exp_long ? 40 : 8;
    resp = {exp_r1, exp_data};
    exp_s = '0;
    for (int i = 0; i < int'(NCR); i++) exp_s = {exp_s[62:0], 1'b1};
    for (int i = 0; i < nresp; i++) exp_s = {exp_s[62:0], resp[39 - i]};
    for (int i = 0; i < 8; i++) exp_s = {exp_s[62:0], 1'b1};
    got_s = '0;
    for (int i = 0; i < int'(NCR) + nresp + 8; i++) begin
      xfer(1'b1, b);
      got_s = {got_s[62:0], b};
    end
    chk({tag, " miso stream"}, got_s, exp_s);
    chk({tag, " strobe count"}, 64'(strobes - s0), 64'd1);
    chk({tag, " last_cmd"}, 64'(last_cmd), 64'(idx));
    chk({tag, " card_ready"}, 64'(card_ready), 64'(exp_ready));
  endtask

  task automatic model_run(input string tag, input logic [5:0] idx, input logic [31:0] arg, input bit bad);
    logic [7:0]  r1;
    logic [31:0] data;
    bit          long;
    model_step(idx, arg, bad, r1, data, long);
    run_cmd(tag, idx, arg, bad, r1, data, long, m_ready != 0);
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  r1;
    logic [31:0] data;
    bit          long;
    bit          ready;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [7:0]  r1;
    logic [31:0] data;
    bit          long;
    logic        d;
    int          s0;

    tbl[0]  = '{6'd0,  32'h0000_0000, 8'h01, 32'h0000_0000, 1'b0, 1'b0};
    tbl[1]  = '{6'd8,  32'h0000_01AA, 8'h01, 32'h0000_01AA, 1'b1, 1'b0};
    tbl[2]  = '{6'd8,  32'h0000_02AA, 8'h01, 32'h0000_00AA, 1'b1, 1'b0};
    tbl[3]  = '{6'd58, 32'h0000_0000, 8'h01, 32'h00FF_8000, 1'b1, 1'b0};
    tbl[4]  = '{6'd17, 32'h0000_0000, 8'h05, 32'h0000_0000, 1'b0, 1'b0};
    tbl[5]  = '{6'd41, 32'h4000_0000, 8'h05, 32'h0000_0000, 1'b0, 1'b0};
    tbl[6]  = '{6'd55, 32'h0000_0000, 8'h01, 32'h0000_0000, 1'b0, 1'b0};
    tbl[7]  = '{6'd41, 32'h4000_0000, 8'h01, 32'h0000_0000, 1'b0, 1'b0};
    tbl[8]  = '{6'd55, 32'h0000_0000, 8'h01, 32'h0000_0000, 1'b0, 1'b0};
    tbl[9]  = '{6'd41, 32'h4000_0000, 8'h01, 32'h0000_0000, 1'b0, 1'b0};
    tbl[10] = '{6'd55, 32'h0000_0000, 8'h01, 32'h0000_0000, 1'b0, 1'b0};
    tbl[11] = '{6'd41, 32'h4000_0000, 8'h00, 32'h0000_0000, 1'b0, 1'b1};
    tbl[12] = '{6'd58, 32'h0000_0000, 8'h00, 32'hC0FF_8000, 1'b1, 1'b1};
    tbl[13] = '{6'd17, 32'h0000_0000, 8'h04, 32'h0000_0000, 1'b0, 1'b1};

    #50;
    chk("reset miso", 64'(miso), 64'd1);
    chk("reset card_ready", 64'(card_ready), 64'd0);
    chk("reset cmd_strobe", 64'(cmd_strobe), 64'd0);
    chk("reset last_cmd", 64'(last_cmd), 64'd0);
    #50;
    rst_n = 1'b1;
    #100;

    // 80 clocks with the card deselected
    for (int i = 0; i < 80; i++) xfer(1'b1, d);
    chk("deselected miso", 64'(miso), 64'd1);

    for (int i = 0; i < 14; i++) begin
      model_step(tbl[i].idx, tbl[i].arg, 1'b0, r1, data, long);
      run_cmd($sformatf("vec%0d", i), tbl[i].idx, tbl[i].arg, 1'b0,
              tbl[i].r1, tbl[i].data, tbl[i].long, tbl[i].ready);
    end

    // Abort mid-frame: no response, card state kept
    s0 = strobes;
    send_bits(mk_frame(6'd17, 32'h0, 1'b0), 20);
    cs_n = 1'b1;
    #200;
    chk("abort frame strobe", 64'(strobes - s0), 64'd0);
    chk("abort frame miso", 64'(miso), 64'd1);
    chk("abort frame card_ready", 64'(card_ready), 64'd1);
    model_run("after abort cmd58", 6'd58, 32'h0, 1'b0);

    // Abort mid-response
    s0 = strobes;
    cs_n = 1'b0;
    model_step(6'd8, 32'h0000_01AA, 1'b0, r1, data, long);
    send_bits(mk_frame(6'd8, 32'h0000_01AA, 1'b0), 48);
    for (int i = 0; i < 12; i++) xfer(1'b1, d);
    cs_n = 1'b1;
    #100;
    chk("abort resp strobe", 64'(strobes - s0), 64'd1);
    chk("abort resp miso", 64'(miso), 64'd1);
    model_run("after abort cmd0", 6'd0, 32'h0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int unsigned kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = $urandom;
      case (kind)
        0: model_run("rnd cmd0", 6'd0, a, 1'b0);
        1: begin
          if ($urandom_range(0, 1) == 1) a[11:8] = 4'h1;
          model_run("rnd cmd8", 6'd8, a, 1'b0);
        end
        2, 3: begin
          model_run("rnd cmd55", 6'd55, 32'h0, 1'b0);
          model_run("rnd acmd41", 6'd41, 32'h4000_0000, 1'b0);
        end
        4: model_run("rnd cmd58", 6'd58, a, 1'b0);
        5: model_run("rnd cmd17", 6'd17, a, 1'b0);
        6: model_run("rnd idx", 6'($urandom_range(0, 63)), a, 1'b0);
        7: model_run("rnd bare41", 6'd41, a, 1'b0);
        default: model_run("rnd cmd55b", 6'd55, a, 1'b0);
      endcase
    end

    model_run("pre crc cmd0", 6'd0, 32'h0, 1'b0);
`ifdef SD_RESP_CRC_CHECK_EN
    model_run("bad crc cmd8", 6'd8, 32'h0000_01AA, 1'b1);
    model_run("good crc cmd8", 6'd8, 32'h0000_01AA, 1'b0);
`endif

    // Drive the card ready, then reset mid-frame
    for (int i = 0; i < int'(BUSY) + 1; i++) begin
      model_run("ready cmd55", 6'd55, 32'h0, 1'b0);
      model_run("ready acmd41", 6'd41, 32'h4000_0000, 1'b0);
    end
    chk("ready before reset", 64'(card_ready), 64'd1);
    send_bits(mk_frame(6'd58, 32'h0, 1'b0), 20);
    rst_n = 1'b0;
    #20;
    chk("midreset miso", 64'(miso), 64'd1);
    chk("midreset card_ready", 64'(card_ready), 64'd0);
    chk("midreset cmd_strobe", 64'(cmd_strobe), 64'd0);
    chk("midreset last_cmd", 64'(last_cmd), 64'd0);
    m_idle = 1; m_ready = 0; m_app = 0; m_polls = 0;
    cs_n = 1'b1;
    #40;
    rst_n = 1'b1;
    #100;
    model_run("post reset cmd58", 6'd58, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
